hsi_m_tx_sched: RTL and testbench

- Schedules the master command link between four frame sources: bit time code (BTC), command word (CCW), telemetry request (TM) and service-data request (SR).
- Sits in front of the master TX controller.
- Arbitrates pending requests, issues one start per frame with a frame-type select, waits for frame completion, and enforces an inter-frame gap.
- All sequencing runs on the TX bit-rate clock enable.

---
 rtl/hsi_m_tx_sched.sv | 224 ++++++++++++++++++++++
 tb/tb_hsi_m_tx_sched.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hsi_m_tx_sched.sv
`default_nettype none
// ============================================================================
// Module      : hsi_m_tx_sched
// Description : Master command-link frame scheduler. Arbitrates BTC (fixed
//               top priority) and CCW/TM/SR (round robin), issues one
//               tx_start per frame with a frame-type select, waits for
//               tx_done, then enforces an inter-frame gap. All sequencing
//               advances only on the TX bit-period enable clk_en.
//               Optional macro HSI_SCHED_TIMEOUT_EN adds a WAIT watchdog
//               with a sticky err_timeout flag.
// Revision    : 1.0 - initial release
// ============================================================================
module hsi_m_tx_sched #(
   parameter int unsigned GAP_BITS     = 4,
   parameter int unsigned TIMEOUT_BITS = 1024
) (
   input  logic       clk,
   input  logic       n_rst,
   input  logic       clk_en,
   input  logic       sched_en,
   input  logic       btc_req,
   input  logic       ccw_req,
   input  logic       tm_req,
   input  logic       sr_req,
   output logic       btc_ack,
   output logic       ccw_ack,
   output logic       tm_ack,
   output logic       sr_ack,
   output logic       tx_start,
   output logic [1:0] tx_sel,
   input  logic       tx_done,
   output logic       busy,
   input  logic       err_clr,
   output logic       err_timeout
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_WAIT  = 2'd2,
      S_GAP   = 2'd3
   } state_t;

   localparam logic [1:0] SEL_BTC  = 2'd0;
   localparam logic [1:0] SEL_CCW  = 2'd1;
   localparam logic [1:0] SEL_TM   = 2'd2;
   localparam logic [1:0] SEL_SR   = 2'd3;
   localparam logic [7:0] GAP_LOAD = GAP_BITS[7:0];

   // Round-robin successor over CCW -> TM -> SR -> CCW
   function automatic logic [1:0] next_src(input logic [1:0] s);
      case (s)
         SEL_CCW: next_src = SEL_TM;
         SEL_TM:  next_src = SEL_SR;
         default: next_src = SEL_CCW;
      endcase
   endfunction

   state_t     state_q, state_d;
   logic       tx_start_q, tx_start_d;
   logic [1:0] tx_sel_q, tx_sel_d;
   logic       busy_q, busy_d;
   logic [3:0] ack_q, ack_d;          // {sr, tm, ccw, btc}
   logic [1:0] rr_ptr_q, rr_ptr_d;
   logic [7:0] gap_cnt_q, gap_cnt_d;

   logic [3:0] req_vec;
   logic [1:0] p0, p1, p2;
   logic       grant_valid;
   logic [1:0] grant_sel;
   logic       frame_end;
   logic       timeout_hit;
   logic       wait_expired;

   // A source whose ack is currently showing has not yet had a chance to drop
   // its level request, so it is masked for that one bit period.
   assign req_vec = {sr_req, tm_req, ccw_req, btc_req} & ~ack_q;

   // Winner selection: BTC outright, else first pending from the pointer on
   always_comb begin
      p0          = rr_ptr_q;
      p1          = next_src(p0);
      p2          = next_src(p1);
      grant_valid = |req_vec;
      grant_sel   = SEL_BTC;
      if (req_vec[0])
         grant_sel = SEL_BTC;
      else if (req_vec[p0])
         grant_sel = p0;
      else if (req_vec[p1])
         grant_sel = p1;
      else if (req_vec[p2])
         grant_sel = p2;
   end

   // Scheduler FSM next-state and registered-output values
   always_comb begin
      state_d     = state_q;
      tx_start_d  = 1'b0;
      tx_sel_d    = tx_sel_q;
      busy_d      = busy_q;
      ack_d       = 4'b0000;
      rr_ptr_d    = rr_ptr_q;
      gap_cnt_d   = gap_cnt_q;
      frame_end   = 1'b0;
      timeout_hit = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (sched_en && grant_valid) begin
               state_d    = S_START;
               tx_start_d = 1'b1;
               tx_sel_d   = grant_sel;
               busy_d     = 1'b1;
               if (grant_sel != SEL_BTC)
                  rr_ptr_d = next_src(grant_sel);
            end
         end
         S_START: begin
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (tx_done) begin
               ack_d[tx_sel_q] = 1'b1;
               frame_end       = 1'b1;
            end else if (wait_expired) begin
               timeout_hit = 1'b1;
               frame_end   = 1'b1;
            end
            if (frame_end) begin
               if (GAP_BITS == 0) begin
                  state_d = S_IDLE;
                  busy_d  = 1'b0;
               end else begin
                  state_d   = S_GAP;
                  gap_cnt_d = GAP_LOAD;
               end
            end
         end
         default: begin
            if (gap_cnt_q <= 8'd1) begin
               state_d   = S_IDLE;
               busy_d    = 1'b0;
               gap_cnt_d = 8'd0;
            end else begin
               gap_cnt_d = gap_cnt_q - 8'd1;
            end
         end
      endcase
   end

   // Scheduler state and outputs, advanced once per bit period
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q    <= S_IDLE;
         tx_start_q <= 1'b0;
         tx_sel_q   <= SEL_BTC;
         busy_q     <= 1'b0;
         ack_q      <= 4'b0000;
         rr_ptr_q   <= SEL_CCW;
         gap_cnt_q  <= 8'd0;
      end else if (clk_en) begin
         state_q    <= state_d;
         tx_start_q <= tx_start_d;
         tx_sel_q   <= tx_sel_d;
         busy_q     <= busy_d;
         ack_q      <= ack_d;
         rr_ptr_q   <= rr_ptr_d;
         gap_cnt_q  <= gap_cnt_d;
      end
   end

`ifdef HSI_SCHED_TIMEOUT_EN
   localparam logic [15:0] TIMEOUT_LIM = TIMEOUT_BITS[15:0];

   logic [15:0] wait_cnt_q, wait_cnt_d, wait_cnt_inc;
   logic        err_timeout_q, err_timeout_d;

   // Saturating count of bit periods already spent in WAIT
   assign wait_cnt_inc = (wait_cnt_q == 16'hFFFF) ? wait_cnt_q : wait_cnt_q + 16'd1;
   assign wait_expired = (wait_cnt_inc >= TIMEOUT_LIM);
   assign err_timeout  = err_timeout_q;

   // Watchdog counter restart on WAIT entry; sticky flag where a new timeout beats err_clr
   always_comb begin
      wait_cnt_d    = wait_cnt_q;
      err_timeout_d = err_timeout_q;
      if (state_q == S_START)
         wait_cnt_d = 16'd0;
      else if (state_q == S_WAIT)
         wait_cnt_d = wait_cnt_inc;
      if (timeout_hit)
         err_timeout_d = 1'b1;
      else if (err_clr)
         err_timeout_d = 1'b0;
   end

   // Watchdog registers, advanced once per bit period
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         wait_cnt_q    <= 16'd0;
         err_timeout_q <= 1'b0;
      end else if (clk_en) begin
         wait_cnt_q    <= wait_cnt_d;
         err_timeout_q <= err_timeout_d;
      end
   end
`else
   logic [17:0] unused_timeout_sigs;

   assign wait_expired        = 1'b0;
   assign err_timeout         = 1'b0;
   assign unused_timeout_sigs = {err_clr, timeout_hit, TIMEOUT_BITS[15:0]};
`endif

   assign tx_start = tx_start_q;
   assign tx_sel   = tx_sel_q;
   assign busy     = busy_q;
   assign btc_ack  = ack_q[0];
   assign ccw_ack  = ack_q[1];
   assign tm_ack   = ack_q[2];
   assign sr_ack   = ack_q[3];

endmodule
`default_nettype wire

// File: tb/tb_hsi_m_tx_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_hsi_m_tx_sched
// Description : Directed self-checking bench for hsi_m_tx_sched (GAP_BITS=4,
//               TIMEOUT_BITS=16). One bit period = two clk cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hsi_m_tx_sched;

   localparam int GAP  = 4;
   localparam int TOUT = 16;

   logic       clk = 1'b0;
   logic       n_rst = 1'b0;
   logic       clk_en = 1'b0;
   logic       sched_en = 1'b1;
   logic       btc_req = 1'b0, ccw_req = 1'b0, tm_req = 1'b0, sr_req = 1'b0;
   logic       btc_ack, ccw_ack, tm_ack, sr_ack;
   logic       tx_start;
   logic [1:0] tx_sel;
   logic       tx_done = 1'b0;
   logic       busy;
   logic       err_clr = 1'b0;
   logic       err_timeout;

   int n_tests = 0;
   int n_fail  = 0;

   hsi_m_tx_sched #(.GAP_BITS(GAP), .TIMEOUT_BITS(TOUT)) dut (
      .clk(clk), .n_rst(n_rst), .clk_en(clk_en), .sched_en(sched_en),
      .btc_req(btc_req), .ccw_req(ccw_req), .tm_req(tm_req), .sr_req(sr_req),
      .btc_ack(btc_ack), .ccw_ack(ccw_ack), .tm_ack(tm_ack), .sr_ack(sr_ack),
      .tx_start(tx_start), .tx_sel(tx_sel), .tx_done(tx_done), .busy(busy),
      .err_clr(err_clr), .err_timeout(err_timeout)
   );

   always #5 clk = ~clk;

   // One bit period: clk_en high for exactly one rising edge; returns at a falling edge
   task automatic tick();
      @(negedge clk);
      clk_en = 1'b1;
      @(negedge clk);
      clk_en = 1'b0;
   endtask

   task automatic do_reset();
      btc_req = 0; ccw_req = 0; tm_req = 0; sr_req = 0;
      tx_done = 0; err_clr = 0; sched_en = 1;
      @(negedge clk);
      n_rst = 1'b0;
      repeat (2) @(negedge clk);
      n_rst = 1'b1;
   endtask

   task automatic wait_start(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (tx_start === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   // Full frame: grant, WAIT of wait_bits periods, ack, then the whole gap
   task automatic run_frame(input int wait_bits, input bit drop, output bit ok,
                            output logic [1:0] sel, output logic [3:0] acks,
                            output logic busy_after);
      wait_start(ok);
      sel = tx_sel;
      tick();
      repeat (wait_bits - 1) tick();
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      acks = {sr_ack, tm_ack, ccw_ack, btc_ack};
      if (drop) begin
         case (sel)
            2'd0: btc_req = 1'b0;
            2'd1: ccw_req = 1'b0;
            2'd2: tm_req  = 1'b0;
            default: sr_req = 1'b0;
         endcase
      end
      repeat (GAP) tick();
      busy_after = busy;
   endtask

   task automatic test_reset();
      logic [9:0] outs;
      do_reset();
      @(negedge clk);
      n_rst = 1'b0;
      ccw_req = 1'b1;
      tick();
      outs = {tx_start, tx_sel, busy, sr_ack, tm_ack, ccw_ack, btc_ack, err_timeout, 1'b0};
      n_tests++;
      if (outs !== 10'd0) begin
         n_fail++;
         $display("FAIL reset_hold: outputs=%b required 0", outs);
      end
      ccw_req = 1'b0;
      n_rst = 1'b1;
      tick();
      n_tests++;
      if ({tx_start, busy} !== 2'b00) begin
         n_fail++;
         $display("FAIL reset_idle: start/busy=%b required 00", {tx_start, busy});
      end
   endtask

   task automatic test_single_ccw();
      do_reset();
      ccw_req = 1'b1;
      tick();
      n_tests++;
      if ({tx_start, tx_sel, busy} !== 4'b1011) begin
         n_fail++;
         $display("FAIL single_grant: start,sel,busy=%b required 1011", {tx_start, tx_sel, busy});
      end
      @(posedge clk); #1;
      n_tests++;
      if (tx_start !== 1'b1) begin
         n_fail++;
         $display("FAIL single_hold_no_en: tx_start=%b required 1", tx_start);
      end
      tick();
      n_tests++;
      if (tx_start !== 1'b0) begin
         n_fail++;
         $display("FAIL single_start_pulse: tx_start=%b required 0", tx_start);
      end
      repeat (8) tick();
      n_tests++;
      if ({ccw_ack, busy, tx_sel} !== 4'b0101) begin
         n_fail++;
         $display("FAIL single_wait: ack,busy,sel=%b required 0101", {ccw_ack, busy, tx_sel});
      end
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      n_tests++;
      if ({sr_ack, tm_ack, ccw_ack, btc_ack, busy} !== 5'b00101) begin
         n_fail++;
         $display("FAIL single_ack: acks,busy=%b required 00101", {sr_ack, tm_ack, ccw_ack, btc_ack, busy});
      end
      ccw_req = 1'b0;
      tick();
      n_tests++;
      if ({ccw_ack, busy} !== 2'b01) begin
         n_fail++;
         $display("FAIL single_ack_pulse: ack,busy=%b required 01", {ccw_ack, busy});
      end
      repeat (2) tick();
      n_tests++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("FAIL single_gap_busy: busy=%b required 1", busy);
      end
      tick();
      n_tests++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL single_gap_end: busy=%b required 0", busy);
      end
   endtask

   task automatic test_round_robin();
      logic [1:0] exp_sel [4];
      logic [1:0] sel;
      logic [3:0] acks;
      logic       b;
      bit         ok;
      exp_sel = '{2'd1, 2'd2, 2'd3, 2'd1};
      do_reset();
      ccw_req = 1; tm_req = 1; sr_req = 1;
      for (int f = 0; f < 4; f++) begin
         run_frame(3, 1'b0, ok, sel, acks, b);
         n_tests++;
         if (!ok || sel !== exp_sel[f] || acks !== (4'b0001 << exp_sel[f]) || b !== 1'b0) begin
            n_fail++;
            $display("FAIL rr_frame%0d: ok=%0d sel=%0d acks=%b busy=%b required sel=%0d acks=%b busy=0",
                     f, ok, sel, acks, b, exp_sel[f], 4'b0001 << exp_sel[f]);
         end
      end
      ccw_req = 0; tm_req = 0; sr_req = 0;
   endtask

   task automatic test_btc_priority();
      logic [1:0] exp_sel [3];
      logic [1:0] sel;
      logic [3:0] acks;
      logic       b;
      bit         ok;
      exp_sel = '{2'd0, 2'd2, 2'd1};
      do_reset();
      ccw_req = 1'b1;
      run_frame(2, 1'b1, ok, sel, acks, b);
      n_tests++;
      if (!ok || sel !== 2'd1 || acks !== 4'b0010) begin
         n_fail++;
         $display("FAIL btc_pre: ok=%0d sel=%0d acks=%b required sel=1 acks=0010", ok, sel, acks);
      end
      btc_req = 1; ccw_req = 1; tm_req = 1;
      for (int f = 0; f < 3; f++) begin
         run_frame(2, 1'b1, ok, sel, acks, b);
         n_tests++;
         if (!ok || sel !== exp_sel[f] || acks !== (4'b0001 << exp_sel[f])) begin
            n_fail++;
            $display("FAIL btc_frame%0d: ok=%0d sel=%0d acks=%b required sel=%0d acks=%b",
                     f, ok, sel, acks, exp_sel[f], 4'b0001 << exp_sel[f]);
         end
      end
   endtask

   task automatic test_sched_en();
      bit seen;
      do_reset();
      ccw_req = 1'b1;
      sr_req  = 1'b1;
      tick();
      tick();
      sched_en = 1'b0;
      repeat (2) tick();
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      n_tests++;
      if ({sr_ack, ccw_ack} !== 2'b01) begin
         n_fail++;
         $display("FAIL sched_ack: sr,ccw ack=%b required 01", {sr_ack, ccw_ack});
      end
      ccw_req = 1'b0;
      repeat (GAP) tick();
      seen = 1'b0;
      repeat (5) begin
         tick();
         if (tx_start !== 1'b0 || busy !== 1'b0) seen = 1'b1;
      end
      n_tests++;
      if (seen) begin
         n_fail++;
         $display("FAIL sched_blocked: activity=%0d required 0", seen);
      end
      sched_en = 1'b1;
      tick();
      n_tests++;
      if ({tx_start, tx_sel} !== 3'b111) begin
         n_fail++;
         $display("FAIL sched_resume: start,sel=%b required 111", {tx_start, tx_sel});
      end
      tick();
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      n_tests++;
      if (sr_ack !== 1'b1) begin
         n_fail++;
         $display("FAIL sched_sr_ack: sr_ack=%b required 1", sr_ack);
      end
      sr_req = 1'b0;
      repeat (GAP) tick();
   endtask

   task automatic test_timeout();
      bit ok;
      do_reset();
      ccw_req = 1'b1;
      tick();
      tick();
`ifdef HSI_SCHED_TIMEOUT_EN
      repeat (TOUT - 1) tick();
      n_tests++;
      if ({err_timeout, busy, sr_ack, tm_ack, ccw_ack, btc_ack} !== 6'b010000) begin
         n_fail++;
         $display("FAIL tout_before: err,busy,acks=%b required 010000",
                  {err_timeout, busy, sr_ack, tm_ack, ccw_ack, btc_ack});
      end
      tick();
      n_tests++;
      if ({err_timeout, busy, sr_ack, tm_ack, ccw_ack, btc_ack} !== 6'b110000) begin
         n_fail++;
         $display("FAIL tout_hit: err,busy,acks=%b required 110000",
                  {err_timeout, busy, sr_ack, tm_ack, ccw_ack, btc_ack});
      end
      repeat (GAP) tick();
      n_tests++;
      if ({err_timeout, busy} !== 2'b10) begin
         n_fail++;
         $display("FAIL tout_gap: err,busy=%b required 10", {err_timeout, busy});
      end
      tick();
      ok = (tx_start === 1'b1) && (tx_sel === 2'd1);
      n_tests++;
      if (!ok) begin
         n_fail++;
         $display("FAIL tout_regrant: start,sel=%b required 101", {tx_start, tx_sel});
      end
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      n_tests++;
      if (err_timeout !== 1'b0) begin
         n_fail++;
         $display("FAIL tout_clear: err_timeout=%b required 0", err_timeout);
      end
`else
      repeat (20) tick();
      ok = 1'b1;
      n_tests++;
      if ({err_timeout, busy, sr_ack, tm_ack, ccw_ack, btc_ack} !== 6'b010000) begin
         n_fail++;
         $display("FAIL nowd_wait: err,busy,acks=%b required 010000",
                  {err_timeout, busy, sr_ack, tm_ack, ccw_ack, btc_ack});
      end
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      n_tests++;
      if ({err_timeout, busy} !== 2'b01) begin
         n_fail++;
         $display("FAIL nowd_clr: err,busy=%b required 01", {err_timeout, busy});
      end
`endif
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      n_tests++;
      if (ccw_ack !== 1'b1) begin
         n_fail++;
         $display("FAIL tout_final_ack: ccw_ack=%b required 1 (ok=%0d)", ccw_ack, ok);
      end
      ccw_req = 1'b0;
      repeat (GAP) tick();
   endtask

   task automatic test_reset_mid();
      logic [8:0] outs;
      do_reset();
      tm_req = 1'b1;
      tick();
      n_tests++;
      if ({tx_start, tx_sel} !== 3'b110) begin
         n_fail++;
         $display("FAIL rmid_grant: start,sel=%b required 110", {tx_start, tx_sel});
      end
      tick();
      sr_req = 1'b1;
      @(negedge clk);
      n_rst = 1'b0;
      #1;
      outs = {tx_start, tx_sel, busy, sr_ack, tm_ack, ccw_ack, btc_ack, err_timeout};
      n_tests++;
      if (outs !== 9'd0) begin
         n_fail++;
         $display("FAIL rmid_async: outputs=%b required 0", outs);
      end
      @(negedge clk);
      n_rst = 1'b1;
      tick();
      n_tests++;
      if ({tx_start, tx_sel} !== 3'b110) begin
         n_fail++;
         $display("FAIL rmid_regrant: start,sel=%b required 110", {tx_start, tx_sel});
      end
   endtask

   initial begin
      test_reset();
      test_single_ccw();
      test_round_robin();
      test_btc_priority();
      test_sched_en();
      test_timeout();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

endmodule
`default_nettype wire
